// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready load/store at a time, LATENCY wait states, byte-enabled storage.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module dmem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | counting down wait states
    // RESP  | response presented until taken
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                lat_we;
    logic [IDX_W-1:0]    lat_idx;
    logic [1:0]          lat_lo;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_be;

    logic                accept;
    logic                commit;
    logic                from_req;
    logic                c_we;
    logic [IDX_W-1:0]    c_idx;
    logic [1:0]          c_lo;
    logic [DATA_W-1:0]   c_wdata;
    logic [NB-1:0]       c_be;
    logic                c_mis;
    logic                unused_addr;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign accept = req_valid_i && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept) state_nxt = (LATENCY > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_lo    <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            cnt       <= 4'(LATENCY);
            lat_we    <= req_we_i;
            lat_idx   <= req_addr_i[IDX_W+1:2];
            lat_lo    <= req_addr_i[1:0];
            lat_wdata <= req_wdata_i;
            lat_be    <= req_be_i;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // With zero wait states the commit happens on the accept edge, so use the live request.
    assign commit   = (state_nxt == RESP) && (state != RESP);
    assign from_req = (state == IDLE);
    assign c_we     = from_req ? req_we_i                : lat_we;
    assign c_idx    = from_req ? req_addr_i[IDX_W+1:2]   : lat_idx;
    assign c_lo     = from_req ? req_addr_i[1:0]         : lat_lo;
    assign c_wdata  = from_req ? req_wdata_i             : lat_wdata;
    assign c_be     = from_req ? req_be_i                : lat_be;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign c_mis = (c_lo != 2'b00);
`else
    assign c_mis = 1'b0;
`endif

    assign unused_addr = ^{req_addr_i[ADDR_W-1:IDX_W+2], c_lo};

    always_ff @(posedge clk) begin
        if (commit && c_we && !c_mis) begin
            for (int b = 0; b < NB; b++) begin
                if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (commit) begin
            rsp_rdata_o <= (c_we || c_mis) ? '0 : mem[c_idx];
            rsp_err_o   <= c_mis;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none, checked against a word-array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    logic [31:0] mdl [2][256];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit is_mis(input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
        return addr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller sits just after a rising edge; returns number of edges from accept to valid.
    task automatic wait_rsp(input int k, output int lat);
        lat = 1;
        while (!rsp_valid[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid[k]) chk("rsp_timeout", 0, 1);
    endtask

    task automatic do_req(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard = 0;
        while (!req_ready[k] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready[k]) chk("req_ready_timeout", 0, 1);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_wdata[k] = $urandom();
        req_addr[k]  = $urandom();
        req_be[k]    = 4'($urandom());
        wait_rsp(k, lat);
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid[k], 1);
            chk("hold_rdata", rsp_rdata[k], rdata);
            chk("hold_ready", req_ready[k], 0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        chk("rsp_drop", rsp_valid[k], 0);
    endtask

    task automatic txn(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall, input string tag);
        logic [7:0]  idx;
        bit          mis;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        idx    = addr[9:2];
        mis    = is_mis(addr);
        exp_rd = (we || mis) ? 32'h0 : mdl[k][idx];
        do_req(k, we, addr, wdata, be, stall, rd, er, lat);
        if (we && !mis) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, er, mis);
        chk({tag, "_lat"}, lat, lat_of(k) + 1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] rd;
        int          lat;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", req_ready[k], 1);
            chk("rst_valid", rsp_valid[k], 0);
            chk("rst_rdata", rsp_rdata[k], 0);
            chk("rst_err", rsp_err[k], 0);
            reset[k] = 1'b0;
        end
        @(posedge clk); #1;

        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 17; w++)
                txn(k, 1'b1, 32'(w * 4), $urandom(), 4'hF, 0, "prefill");

        // basic store then load
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10");
        chk("ld10_const", mdl[0][4], 32'hDEADBEEF);

        // partial byte enables
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "st20");
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, "st20be");
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20");
        chk("ld20_const", mdl[0][8], 32'h11BB33DD);
        txn(0, 1'b1, 32'h24, 32'h0, 4'h0, 0, "st_be0");

        // stalled response with a request waiting behind it
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        rd = rsp_rdata[0];
        chk("stall_rdata", rd, 32'hDEADBEEF);
        for (int s = 0; s < 5; s++) begin
            if (s == 2) begin
                req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h20;
            end
            @(posedge clk); #1;
            chk("stall_valid", rsp_valid[0], 1);
            chk("stall_hold", rsp_rdata[0], rd);
            chk("stall_ready", req_ready[0], 0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        chk("post_hs_valid", rsp_valid[0], 0);
        chk("post_hs_ready", req_ready[0], 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("second_accepted", req_ready[0], 0);
        wait_rsp(0, lat);
        chk("second_lat", lat, 3);
        chk("second_rdata", rsp_rdata[0], mdl[0][8]);
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;

        // zero wait states and address aliasing
        txn(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 0, "l0_st40");
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 1, "l0_ld40");
        txn(1, 1'b1, 32'h440, 32'h76543210, 4'hF, 0, "l0_alias_st");
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, "l0_alias_ld");
        chk("alias_const", mdl[1][16], 32'h76543210);

        // reset during WAIT drops the uncommitted store
        txn(0, 1'b1, 32'h8, 32'h1, 4'hF, 0, "st8");
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8; req_wdata[0] = 32'h5; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset[0] = 1'b1;
        #1;
        chk("midrst_ready", req_ready[0], 1);
        chk("midrst_valid", rsp_valid[0], 0);
        chk("midrst_rdata", rsp_rdata[0], 0);
        chk("midrst_err", rsp_err[0], 0);
        @(posedge clk); #1;
        reset[0] = 1'b0;
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, "ld8_after_rst");
        chk("ld8_const", mdl[0][2], 32'h1);

        // misaligned store
        txn(0, 1'b1, 32'h22, 32'hCAFEF00D, 4'hF, 0, "st22");
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20_after22");
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_const", mdl[0][8], 32'h11BB33DD);
`else
        chk("mis_const", mdl[0][8], 32'hCAFEF00D);
`endif

        // random traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                r = $urandom();
                txn(k, 1'($urandom_range(0, 1)), {r[31:10], 4'h0, 4'($urandom_range(0, 15)), r[1:0]},
                    $urandom(), 4'($urandom()), $urandom_range(0, 3), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
